// File: rtl/ram_port_arbiter.sv
// Two-master arbiter for a single-port data RAM: the CPU data path and an
// external loader/debug port share one RAM port. Ownership is registered and
// the RAM port is driven only by the current owner. While both masters want
// the port, the external side may hold it for a bounded burst before the CPU
// gets one access.
module ram_port_arbiter #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_gnt,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_EXT  = 2'd2
  } owner_t;

  // One spare bit so the counter can pass the limit without wrapping.
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [BW-1:0] BURST_SAT  = {BW{1'b1}};

  owner_t            owner_r;
  owner_t            last_served_r;
  owner_t            next_owner_s;
  logic [BW-1:0]     burst_cnt_r;
  logic [15:0]       conflict_cnt_r;
  logic              served_s;
  logic              mux_we_s;
  logic [ADDR_W-1:0] mux_addr_s;
  logic [DATA_W-1:0] mux_wdata_s;

  // RAM port is sourced from the current owner only; an idle port is all zero.
  always_comb begin
    mux_we_s    = 1'b0;
    mux_addr_s  = {ADDR_W{1'b0}};
    mux_wdata_s = {DATA_W{1'b0}};
    case (owner_r)
      OWN_CPU: begin
        mux_we_s    = cpu_req & cpu_we;
        mux_addr_s  = cpu_addr;
        mux_wdata_s = cpu_wdata;
      end
      OWN_EXT: begin
        mux_we_s    = ext_req & ext_we;
        mux_addr_s  = ext_addr;
        mux_wdata_s = ext_wdata;
      end
      default: begin
        mux_we_s    = 1'b0;
        mux_addr_s  = {ADDR_W{1'b0}};
        mux_wdata_s = {DATA_W{1'b0}};
      end
    endcase
  end

  // Reset overrides the handshake so an in-flight access can never write.
  assign ram_we       = reset ? 1'b0 : mux_we_s;
  assign ram_addr     = mux_addr_s;
  assign ram_wdata    = mux_wdata_s;
  assign cpu_rdata    = ram_rdata;
  assign ext_rdata    = ram_rdata;
  assign cpu_stall    = reset ? cpu_req : (cpu_req & (owner_r != OWN_CPU));
  assign ext_gnt      = reset ? 1'b0    : (ext_req & (owner_r == OWN_EXT));
  assign conflict_cnt = conflict_cnt_r;

  // An access completes when its master owns the port and still requests.
  assign served_s = ((owner_r == OWN_CPU) & cpu_req) |
                    ((owner_r == OWN_EXT) & ext_req);

  // Choose the owner for the next cycle from the current requests.
  always_comb begin
    next_owner_s = OWN_NONE;
    case ({cpu_req, ext_req})
      2'b00: next_owner_s = OWN_NONE;
      2'b10: next_owner_s = OWN_CPU;
      2'b01: next_owner_s = OWN_EXT;
      2'b11: begin
        case (owner_r)
          OWN_CPU: next_owner_s = OWN_EXT;
          OWN_EXT: begin
            // >= rather than == so a long solo EXT run cannot starve the CPU.
            if (burst_cnt_r >= BURST_LAST) begin
              next_owner_s = OWN_CPU;
            end else begin
              next_owner_s = OWN_EXT;
            end
          end
          OWN_NONE: begin
            if (last_served_r == OWN_EXT) begin
              next_owner_s = OWN_CPU;
            end else begin
              next_owner_s = OWN_EXT;
            end
          end
          default: next_owner_s = OWN_NONE;
        endcase
      end
      default: next_owner_s = OWN_NONE;
    endcase
  end

  // Ownership state, fairness history, burst length and conflict statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_r        <= OWN_NONE;
      last_served_r  <= OWN_EXT;
      burst_cnt_r    <= {BW{1'b0}};
      conflict_cnt_r <= 16'd0;
    end else begin
      owner_r <= next_owner_s;

      if (served_s) begin
        last_served_r <= owner_r;
      end else begin
        last_served_r <= last_served_r;
      end

      if (next_owner_s != OWN_EXT) begin
        burst_cnt_r <= {BW{1'b0}};
      end else if ((owner_r == OWN_EXT) && ext_req && (burst_cnt_r != BURST_SAT)) begin
        burst_cnt_r <= burst_cnt_r + {{(BW-1){1'b0}}, 1'b1};
      end else begin
        burst_cnt_r <= burst_cnt_r;
      end

      if (cpu_stall && (conflict_cnt_r != 16'hFFFF)) begin
        conflict_cnt_r <= conflict_cnt_r + 16'd1;
      end else begin
        conflict_cnt_r <= conflict_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a small behavioural RAM attached.
module tb_ram_port_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, ext_req, ext_we;
  logic [4:0]  cpu_addr, ext_addr;
  logic [31:0] cpu_wdata, ext_wdata;
  logic [31:0] cpu_rdata, ext_rdata;
  logic        cpu_stall, ext_gnt, ram_we;
  logic [4:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [15:0] conflict_cnt;

  int total;
  int bad;

  logic [31:0] mem [0:31];

  ram_port_arbiter #(.ADDR_W(5), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_gnt(ext_gnt),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: combinational read, write at the rising edge.
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 5'd0; cpu_wdata = 32'd0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = 5'd0; ext_wdata = 32'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; ext_req = 1'b1; ext_we = 1'b1;
    step(); step();
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%0h exp=0", ram_we); end
    total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL rst_stall got=%0h exp=1", cpu_stall); end
    total++; if (ext_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt got=%0h exp=0", ext_gnt); end
    total++; if (conflict_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0h exp=0", conflict_cnt); end
    reset = 1'b0;
    idle_inputs();
    #1;
    total++; if (ram_addr !== 5'd0 || ram_wdata !== 32'd0) begin bad++; $display("FAIL rst_idle_port addr=%0h wdata=%0h exp=0/0", ram_addr, ram_wdata); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL rst_idle_stall got=%0h exp=0", cpu_stall); end
    // CPU owns and is writing when reset rises: override must hold.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd2;
    step();
    reset = 1'b1;
    #1;
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL rst_cpu_we got=%0h exp=0", ram_we); end
    total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL rst_cpu_stall got=%0h exp=1", cpu_stall); end
    do_reset();
  endtask

  task automatic test_cpu_store();
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd3; cpu_wdata = 32'hA5;
    #1;
    total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL st_c1_stall got=%0h exp=1", cpu_stall); end
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL st_c1_we got=%0h exp=0", ram_we); end
    step();
    total++; if (ram_we !== 1'b1 || ram_addr !== 5'd3 || ram_wdata !== 32'hA5) begin bad++; $display("FAIL st_c2_port we=%0h addr=%0h wdata=%0h exp=1/3/a5", ram_we, ram_addr, ram_wdata); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL st_c2_stall got=%0h exp=0", cpu_stall); end
    step();
    cpu_req = 1'b0;
    #1;
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL st_drop_we got=%0h exp=0", ram_we); end
    total++; if (mem[3] !== 32'hA5) begin bad++; $display("FAIL st_mem got=%0h exp=a5", mem[3]); end
    total++; if (conflict_cnt !== 16'd1) begin bad++; $display("FAIL st_cnt got=%0h exp=1", conflict_cnt); end
    total++; if (cpu_rdata !== 32'hA5) begin bad++; $display("FAIL st_rdata got=%0h exp=a5", cpu_rdata); end
    step();
    total++; if (ram_addr !== 5'd0) begin bad++; $display("FAIL st_none_addr got=%0h exp=0", ram_addr); end
  endtask

  task automatic test_both_from_none();
    do_reset();
    cpu_req = 1'b1; cpu_addr = 5'd1; ext_req = 1'b1; ext_addr = 5'd2;
    #1;
    total++; if (cpu_stall !== 1'b1 || ext_gnt !== 1'b0) begin bad++; $display("FAIL both_c1 stall=%0h gnt=%0h exp=1/0", cpu_stall, ext_gnt); end
    step();
    total++; if (cpu_stall !== 1'b0 || ext_gnt !== 1'b0 || ram_addr !== 5'd1) begin bad++; $display("FAIL both_c2 stall=%0h gnt=%0h addr=%0h exp=0/0/1", cpu_stall, ext_gnt, ram_addr); end
    step();
    total++; if (cpu_stall !== 1'b1 || ext_gnt !== 1'b1 || ram_addr !== 5'd2) begin bad++; $display("FAIL both_c3 stall=%0h gnt=%0h addr=%0h exp=1/1/2", cpu_stall, ext_gnt, ram_addr); end
    total++; if (conflict_cnt !== 16'd1) begin bad++; $display("FAIL both_cnt got=%0h exp=1", conflict_cnt); end
    idle_inputs();
    step();
  endtask

  task automatic test_ext_burst();
    logic exp_ext;
    do_reset();
    ext_req = 1'b1; ext_addr = 5'd4;
    #1;
    total++; if (ext_gnt !== 1'b0) begin bad++; $display("FAIL burst_c1_gnt got=%0h exp=0", ext_gnt); end
    step();
    cpu_req = 1'b1; cpu_addr = 5'd5;
    // EXT holds for four cycles, CPU gets one, then the pattern repeats.
    for (int i = 0; i < 10; i++) begin
      exp_ext = ((i % 5) != 4);
      #1;
      total++;
      if (ext_gnt !== exp_ext || cpu_stall !== exp_ext) begin
        bad++;
        $display("FAIL burst_cyc%0d gnt=%0h stall=%0h exp=%0h/%0h", i, ext_gnt, cpu_stall, exp_ext, exp_ext);
      end
      step();
    end
    total++; if (conflict_cnt !== 16'd8) begin bad++; $display("FAIL burst_cnt got=%0d exp=8", conflict_cnt); end
    idle_inputs();
    step();
  endtask

  task automatic test_ext_write_read();
    do_reset();
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 5'd9; ext_wdata = 32'hCAFEF00D;
    step();
    total++; if (ext_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 5'd9) begin bad++; $display("FAIL extw gnt=%0h we=%0h addr=%0h exp=1/1/9", ext_gnt, ram_we, ram_addr); end
    step();
    ext_we = 1'b0;
    #1;
    total++; if (ext_rdata !== 32'hCAFEF00D || ram_we !== 1'b0) begin bad++; $display("FAIL extr rdata=%0h we=%0h exp=cafef00d/0", ext_rdata, ram_we); end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 5'd7; ext_wdata = 32'h11111111;
    step();
    step();
    ext_wdata = 32'hDEADBEEF;
    reset = 1'b1;
    #1;
    total++; if (ram_we !== 1'b0 || ext_gnt !== 1'b0) begin bad++; $display("FAIL rmid_we we=%0h gnt=%0h exp=0/0", ram_we, ext_gnt); end
    step();
    reset = 1'b0;
    ext_req = 1'b0;
    #1;
    total++; if (ram_addr !== 5'd0 || ext_gnt !== 1'b0) begin bad++; $display("FAIL rmid_none addr=%0h gnt=%0h exp=0/0", ram_addr, ext_gnt); end
    total++; if (mem[7] !== 32'h11111111) begin bad++; $display("FAIL rmid_mem got=%0h exp=11111111", mem[7]); end
    ext_req = 1'b1; ext_we = 1'b0;
    step();
    total++; if (ext_gnt !== 1'b1 || ext_rdata !== 32'h11111111) begin bad++; $display("FAIL rmid_read gnt=%0h rdata=%0h exp=1/11111111", ext_gnt, ext_rdata); end
    idle_inputs();
    step();
  endtask

  task automatic test_saturate();
    do_reset();
    cpu_req = 1'b1; ext_req = 1'b1;
    // Cycle 1 stalls (owner idle), then each 5-cycle turn adds 4 stalls.
    for (int i = 0; i < 81916; i++) step();
    total++; if (conflict_cnt !== 16'd65533 || cpu_stall !== 1'b0) begin bad++; $display("FAIL sat_near cnt=%0d stall=%0h exp=65533/0", conflict_cnt, cpu_stall); end
    for (int i = 0; i < 3; i++) step();
    total++; if (conflict_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hit got=%0h exp=ffff", conflict_cnt); end
    for (int i = 0; i < 2; i++) step();
    total++; if (conflict_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%0h exp=ffff", conflict_cnt); end
    idle_inputs();
    step();
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_cpu_store();
    test_both_from_none();
    test_ext_burst();
    test_ext_write_read();
    test_reset_mid_write();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
